// File: rtl/ysyx_22051013_fetch_buf.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_fetch_buf
//
// Instruction-fetch front end. Generates sequential fetch PCs, issues
// pipelined requests to instruction memory, collects in-order responses
// into a DEPTH-entry prefetch queue and hands (pc, inst) pairs to decode.
// A redirect flushes the queue and arranges for still-outstanding
// responses to be discarded as they return.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   req_valid/ready    fetch request handshake, req_addr = fetch PC
//   rsp_valid/data     in-order memory responses, no backpressure
//   out_valid/ready    decode handshake, out_pc/out_inst = queue head
//   redirect/_pc       flush and restart fetch at redirect_pc (low bits cleared)
// ---------------------------------------------------------------------------
module ysyx_22051013_fetch_buf #(
  parameter int unsigned       PC_W     = 64,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [PC_W-1:0]   req_addr,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  ptr_t              alloc_q, alloc_d;
  ptr_t              fill_q, fill_d;
  ptr_t              head_q, head_d;
  cnt_t              used_q, used_d;
  // Allocated slots still waiting for their response.
  cnt_t              pend_q, pend_d;
  // Responses still owed for requests issued before a redirect.
  cnt_t              drop_q, drop_d;
  logic [DEPTH-1:0]  filled_q, filled_d;

  logic [PC_W-1:0]   slot_pc_q   [DEPTH];
  logic [INST_W-1:0] slot_inst_q [DEPTH];

  logic [CNT_W:0]    credit_sum;
  logic              req_fire;
  logic              rsp_fill;
  logic              rsp_drop;
  logic              out_fire;

  // Every request reserves room for its response: live entries plus
  // responses still to be dropped may never exceed DEPTH.
  assign credit_sum = {1'b0, used_q} + {1'b0, drop_q};
  // rst gates req_valid so nothing is requested while reset is held.
  assign req_valid  = rst && !redirect && (credit_sum < (CNT_W+1)'(DEPTH));
  assign req_addr   = fetch_pc_q;
  assign req_fire   = req_valid && req_ready;

  assign rsp_drop   = rsp_valid && (drop_q != '0);
  assign rsp_fill   = rsp_valid && (drop_q == '0);

  assign out_valid  = (used_q != '0) && filled_q[head_q];
  assign out_pc     = slot_pc_q[head_q];
  assign out_inst   = slot_inst_q[head_q];
  assign out_fire   = out_valid && out_ready;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    used_d     = used_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    filled_d   = filled_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~{{(PC_W-2){1'b0}}, 2'b11};
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      used_d     = '0;
      pend_d     = '0;
      filled_d   = '0;
      // Every unanswered request becomes a response to discard; a response
      // arriving right now already settles one of them.
      drop_d     = drop_q + pend_q - cnt_t'(rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d        = fetch_pc_q + PC_W'(4);
        alloc_d           = alloc_q + ptr_t'(1);
        filled_d[alloc_q] = 1'b0;
      end
      if (rsp_drop) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (rsp_fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + ptr_t'(1);
      end
      if (out_fire) begin
        head_d = head_q + ptr_t'(1);
      end
      used_d = used_q + cnt_t'(req_fire) - cnt_t'(out_fire);
      pend_d = pend_q + cnt_t'(req_fire) - cnt_t'(rsp_fill);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      used_q     <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      used_q     <= used_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  // Slot payload storage. A redirect leaves it untouched; the filled bits
  // and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the slot array is reset because out_pc/out_inst are read
      // straight from the head slot and must come out of reset as zero.
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_pc_q[i]   <= '0;
        slot_inst_q[i] <= '0;
      end
    end else begin
      if (req_fire) begin
        slot_pc_q[alloc_q] <= fetch_pc_q;
      end
      if (rsp_fill && !redirect) begin
        slot_inst_q[fill_q] <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_fetch_buf.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_22051013_fetch_buf. The bench plays instruction memory
// (in-order responses, configurable latency, data = address ^ 0x80000000)
// and keeps a transaction-level queue model of the fetch buffer. Every
// cycle the DUT outputs are compared against the model; directed phases
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ysyx_22051013_fetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect;
  logic [63:0] redirect_pc;

  always #5 clk = ~clk;

  ysyx_22051013_fetch_buf #(
    .PC_W    (64),
    .INST_W  (32),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  // Model: live queue entries in program order, plus responses to discard.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;
  ent_t        mq[$];
  int          m_drop;
  logic [63:0] m_pc;

  // Memory: outstanding requests in order, each with its due cycle.
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem[$];
  int    lat_lo = 1;
  int    lat_hi = 1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;

  logic        obs_req_valid, obs_req_fire, obs_out_valid;
  logic [63:0] obs_req_addr, obs_out_pc;
  logic [31:0] obs_out_inst;
  bit          saw_top;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h8000_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_pc   = RESET_PC;
    mem.delete();
  endtask

  // Hold reset for n edges, then check the reset state and release.
  task automatic do_reset(input int n);
    rst = 1'b0; req_ready = 1'b0; out_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    #1;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_addr",  req_addr, RESET_PC);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc",    out_pc, 64'd0);
    check("rst_out_inst",  64'(out_inst), 64'd0);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic step(input bit rr, input bit orr, input bit rd, input logic [63:0] rpc);
    bit          e_req_valid, e_out_valid, rsp, found;
    logic [31:0] rdata;
    int          unfilled;
    req_ready   = rr;
    out_ready   = orr;
    redirect    = rd;
    redirect_pc = rpc;
    if (mem.size() > 0 && mem[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_data(mem[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #1;
    e_req_valid = !rd && (mq.size() + m_drop < DEPTH);
    e_out_valid = (mq.size() > 0) && mq[0].filled;
    check("req_valid", 64'(req_valid), 64'(e_req_valid));
    check("req_addr",  req_addr, m_pc);
    check("out_valid", 64'(out_valid), 64'(e_out_valid));
    if (e_out_valid && out_valid) begin
      check("out_pc",   out_pc, mq[0].pc);
      check("out_inst", 64'(out_inst), 64'(mq[0].inst));
    end
    obs_req_valid = req_valid;
    obs_req_fire  = req_valid && rr;
    obs_req_addr  = req_addr;
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    obs_out_inst  = out_inst;
    rsp   = rsp_valid;
    rdata = rsp_data;

    @(posedge clk);
    if (rsp) mem.pop_front();
    if (obs_req_fire) begin
      mem.push_back('{addr: obs_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
      if (obs_req_addr == 64'hFFFF_FFFF_FFFF_FFFC) saw_top = 1'b1;
    end

    if (e_out_valid && orr) n_out++;
    if (rd) begin
      unfilled = 0;
      foreach (mq[i]) if (!mq[i].filled) unfilled++;
      m_drop = m_drop + unfilled - (rsp ? 1 : 0);
      mq.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (rsp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          found = 1'b0;
          foreach (mq[i]) begin
            if (!found && !mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].inst   = rdata;
              found        = 1'b1;
            end
          end
          check("rsp_has_slot", 64'(found), 64'd1);
        end
      end
      if (e_out_valid && orr) void'(mq.pop_front());
      if (e_req_valid && rr) begin
        mq.push_back('{pc: m_pc, inst: 32'h0, filled: 1'b0});
        m_pc = m_pc + 64'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Step with full handshake until the first output appears; pin its value.
  task automatic wait_first_out(input string name, input logic [63:0] exp_pc);
    int k = 0;
    do begin
      step(1'b1, 1'b1, 1'b0, 64'h0);
      k++;
    end while (!obs_out_valid && k < 20);
    check({name, "_valid"}, 64'(obs_out_valid), 64'd1);
    check({name, "_pc"},    obs_out_pc, exp_pc);
    check({name, "_inst"},  64'(obs_out_inst), 64'(mem_data(exp_pc)));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nreq;
    int guard;
    int n_redir;
    bit rd;
    logic [63:0] rpc;

    // Back-to-back fetch with 1-cycle memory.
    do_reset(3);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0);
      check("seq_req_addr", obs_req_addr, RESET_PC + 64'(4 * i));
      if (i >= 2) begin
        check("seq_out_valid", 64'(obs_out_valid), 64'd1);
        check("seq_out_pc",    obs_out_pc, RESET_PC + 64'(4 * (i - 2)));
        check("seq_out_inst",  64'(obs_out_inst), 64'(4 * (i - 2)));
      end
    end

    // Decode stalled: exactly DEPTH requests, then drain in order.
    do_reset(1);
    nreq = 0;
    repeat (10) begin
      step(1'b1, 1'b0, 1'b0, 64'h0);
      nreq += int'(obs_req_fire);
    end
    check("stall_req_count", 64'(nreq), 64'(DEPTH));
    check("stall_req_valid", 64'(obs_req_valid), 64'd0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("drain_first_pc", obs_out_pc, RESET_PC);
    repeat (12) step(1'b1, 1'b1, 1'b0, 64'h0);

    // Latency 3, redirect with three requests in flight.
    do_reset(1);
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_1002);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("redir_req_valid", 64'(obs_req_valid), 64'd1);
    check("redir_req_addr",  obs_req_addr, 64'h8000_1000);
    wait_first_out("redir_first", 64'h8000_1000);
    repeat (8) step(1'b1, 1'b1, 1'b0, 64'h0);

    // Redirect coinciding with a response and an output handshake.
    do_reset(1);
    lat_lo = 1; lat_hi = 1;
    repeat (4) step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_2000);
    check("coincide_out_valid", 64'(obs_out_valid), 64'd1);
    wait_first_out("coincide_first", 64'h8000_2000);
    repeat (6) step(1'b1, 1'b1, 1'b0, 64'h0);

    // PC wrap through the top of the address space.
    step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
    wait_first_out("wrap_first", 64'hFFFF_FFFF_FFFF_FFF4);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("wrap_pc1", obs_out_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("wrap_pc2", obs_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("wrap_pc3", obs_out_pc, 64'h0);

    // Randomised traffic with random redirects.
    do_reset(1);
    lat_lo = 1; lat_hi = 4;
    n_out = 0; n_redir = 0; guard = 0; saw_top = 1'b0;
    while (n_out < 1000 && guard < 20000) begin
      rd = (n_redir < 50) && ($urandom_range(29, 0) == 0);
      if ($urandom_range(1, 0) == 0) rpc = {$urandom, $urandom};
      else rpc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(31, 0));
      if (rd) n_redir++;
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, rd, rpc);
      guard++;
    end
    check("random_out_done", 64'(n_out >= 1000), 64'd1);
    check("random_saw_top",  64'(saw_top), 64'd1);

    // Reset in the middle of traffic with three live entries.
    do_reset(1);
    lat_lo = 1; lat_hi = 1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 64'h0);
    do_reset(1);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("post_rst_req_valid", 64'(obs_req_valid), 64'd1);
    check("post_rst_req_addr",  obs_req_addr, RESET_PC);
    check("post_rst_out_valid", 64'(obs_out_valid), 64'd0);
    wait_first_out("post_rst_first", RESET_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
